// File: rtl/scr1_imem_insn_matcher.sv
// Instruction-match monitor beside the IMEM bridge: N_CH programmable mask/value channels
// count hits on OK fetch words and log one {channel, insn, snapshot} record per cycle into a FIFO.
module scr1_imem_insn_matcher #(
    parameter  int N_CH    = 4,
    parameter  int DEPTH   = 8,
    parameter  int SNAP_W  = 64,
    parameter  int CNT_W   = 16,
    parameter  int ONESHOT = 0,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_idx,
    input  logic                  cfg_en,
    input  logic [31:0]           cfg_mask,
    input  logic [31:0]           cfg_value,
    input  logic [1:0]            imem_resp,
    input  logic [31:0]           imem_rdata,
    input  logic [SNAP_W-1:0]     snap_data,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [CH_W-1:0]       evt_ch,
    output logic [31:0]           evt_insn,
    output logic [SNAP_W-1:0]     evt_snap,
    output logic [N_CH*CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic [LVL_W-1:0]      fifo_level
);

    localparam int                AW      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;
    localparam logic [LVL_W-1:0]  PTR_ONE = 1;
    localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(DEPTH);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [31:0]       insn;
        logic [SNAP_W-1:0] snap;
    } rec_t;

    logic [N_CH-1:0]  en_q;
    logic [N_CH-1:0]  armed_q;
    logic [31:0]      mask_q  [N_CH];
    logic [31:0]      value_q [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] drop_q;
    logic [LVL_W-1:0] wr_q;
    logic [LVL_W-1:0] rd_q;
    rec_t             mem_q   [DEPTH];

    logic             resp_ok;
    logic [N_CH-1:0]  hit;
    logic [N_CH-1:0]  log_ok;
    logic [N_CH-1:0]  cfg_sel;
    logic             push;
    logic [CH_W-1:0]  push_ch;
    logic [LVL_W-1:0] level;
    logic             full;
    logic             pop;
    logic             accept;
    logic             drop;
    rec_t             head;

    assign resp_ok = (imem_resp == 2'b01);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hit     = '0;
        log_ok  = '0;
        cfg_sel = '0;
        push    = 1'b0;
        push_ch = '0;
        for (int i = 0; i < N_CH; i++) begin
            hit[i]     = resp_ok & en_q[i] & ((imem_rdata & mask_q[i]) == value_q[i]);
            log_ok[i]  = hit[i] & ((ONESHOT == 0) | armed_q[i]);
            cfg_sel[i] = cfg_we & (int'(cfg_idx) == i);
        end
        // Scan downwards so the lowest-index logging channel is the one left standing.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (log_ok[i]) begin
                push    = 1'b1;
                push_ch = CH_W'(i);
            end
        end
    end

    assign level  = wr_q - rd_q;
    assign full   = (level == LVL_MAX);
    assign pop    = evt_valid & evt_ready;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;
    assign head   = mem_q[rd_q[AW-1:0]];

    assign evt_valid  = (level != '0);
    assign evt_ch     = head.ch;
    assign evt_insn   = head.insn;
    assign evt_snap   = head.snap;
    assign drop_cnt   = drop_q;
    assign fifo_level = level;

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            hit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    // NOTE: non-blocking assignments here, so every update in this block sees pre-edge state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= '0;
            armed_q <= '1;
            drop_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                mask_q[i]  <= '0;
                value_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            // NOTE: the record store is reset because evt_* must read 0 out of reset; it is small.
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_sel[i]) begin
                    en_q[i]    <= cfg_en;
                    mask_q[i]  <= cfg_mask;
                    value_q[i] <= cfg_value;
                    cnt_q[i]   <= '0;
                    armed_q[i] <= 1'b1;
                end else begin
                    if (hit[i] && (cnt_q[i] != '1)) begin
                        cnt_q[i] <= cnt_q[i] + CNT_ONE;
                    end
                    // The one shot is spent whether the record was stored or dropped.
                    if ((ONESHOT != 0) && push && (push_ch == CH_W'(i))) begin
                        armed_q[i] <= 1'b0;
                    end
                end
            end
            if (accept) begin
                mem_q[wr_q[AW-1:0]] <= '{ch: push_ch, insn: imem_rdata, snap: snap_data};
                wr_q                <= wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_q <= rd_q + PTR_ONE;
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_scr1_imem_insn_matcher.sv
// Directed bench for scr1_imem_insn_matcher: a vector table for single-cycle behaviour plus
// hand-written sequences for FIFO fill/drop/drain, async reset and one-shot logging.
module tb_scr1_imem_insn_matcher;

    localparam int N_CH   = 4;
    localparam int DEPTH  = 8;
    localparam int SNAP_W = 64;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;
    localparam int LVL_W  = 4;

    logic                  clk;
    logic                  rst;
    logic                  cfg_we;
    logic [CH_W-1:0]       cfg_idx;
    logic                  cfg_en;
    logic [31:0]           cfg_mask;
    logic [31:0]           cfg_value;
    logic [1:0]            imem_resp;
    logic [31:0]           imem_rdata;
    logic [SNAP_W-1:0]     snap_data;
    logic                  evt_ready;

    logic                  a_valid, b_valid;
    logic [CH_W-1:0]       a_ch, b_ch;
    logic [31:0]           a_insn, b_insn;
    logic [SNAP_W-1:0]     a_snap, b_snap;
    logic [N_CH*CNT_W-1:0] a_hit_cnt, b_hit_cnt;
    logic [CNT_W-1:0]      a_drop, b_drop;
    logic [LVL_W-1:0]      a_level, b_level;

    int n_checks = 0;
    int n_errors = 0;

    scr1_imem_insn_matcher #(
        .N_CH(N_CH), .DEPTH(DEPTH), .SNAP_W(SNAP_W), .CNT_W(CNT_W), .ONESHOT(0)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_mask(cfg_mask), .cfg_value(cfg_value),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata), .snap_data(snap_data),
        .evt_valid(a_valid), .evt_ready(evt_ready), .evt_ch(a_ch),
        .evt_insn(a_insn), .evt_snap(a_snap),
        .hit_cnt(a_hit_cnt), .drop_cnt(a_drop), .fifo_level(a_level)
    );

    scr1_imem_insn_matcher #(
        .N_CH(N_CH), .DEPTH(DEPTH), .SNAP_W(SNAP_W), .CNT_W(CNT_W), .ONESHOT(1)
    ) u_one (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_mask(cfg_mask), .cfg_value(cfg_value),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata), .snap_data(snap_data),
        .evt_valid(b_valid), .evt_ready(evt_ready), .evt_ch(b_ch),
        .evt_insn(b_insn), .evt_snap(b_snap),
        .hit_cnt(b_hit_cnt), .drop_cnt(b_drop), .fifo_level(b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  idx;
        logic        en;
        logic [31:0] mask;
        logic [31:0] value;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_valid;
        logic [1:0]  exp_ch;
        logic [31:0] exp_insn;
        int          exp_level;
        int          exp_cnt0;
        int          exp_cnt1;
        int          exp_drop;
    } vec_t;

    vec_t vecs [13];

    localparam logic [31:0] XOR_M = 32'h0000_707F;
    localparam logic [31:0] XOR_V = 32'h0000_4033;
    localparam logic [31:0] I_XOR = 32'h00C5_C533;
    localparam logic [31:0] I_ADD = 32'h00B5_0533;
    localparam logic [31:0] I_NOP = 32'h0000_0013;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] idx, input logic en,
                         input logic [31:0] mask, input logic [31:0] value,
                         input logic [1:0] resp, input logic [31:0] rdata, input logic ready);
        cfg_we     = we;
        cfg_idx    = idx;
        cfg_en     = en;
        cfg_mask   = mask;
        cfg_value  = value;
        imem_resp  = resp;
        imem_rdata = rdata;
        snap_data  = {rdata, ~rdata};
        evt_ready  = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // XOR words differing only in rd, so each record is distinguishable.
    function automatic logic [31:0] xw(input int k);
        return 32'h00C5_C033 | (32'(k) << 7);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_w;

        vecs[0]  = '{1'b1, 2'd0, 1'b1, XOR_M, XOR_V, 2'b00, 32'h0, 1'b0,  1'b0, 2'd0, 32'h0, 0, 0, 0, 0};
        vecs[1]  = '{1'b1, 2'd1, 1'b1, 32'h7F, 32'h33, 2'b00, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 0, 0, 0, 0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b01, I_XOR, 1'b0,   1'b1, 2'd0, I_XOR, 1, 1, 1, 0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b01, I_ADD, 1'b0,   1'b1, 2'd0, I_XOR, 2, 1, 2, 0};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b10, I_XOR, 1'b0,   1'b1, 2'd0, I_XOR, 2, 1, 2, 0};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b1,   1'b1, 2'd1, I_ADD, 1, 1, 2, 0};
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b01, I_NOP, 1'b1,   1'b0, 2'd0, 32'h0, 0, 1, 2, 0};
        vecs[7]  = '{1'b1, 2'd0, 1'b1, 32'h7F, 32'h13, 2'b01, I_XOR, 1'b0, 1'b1, 2'd0, I_XOR, 1, 0, 3, 0};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b01, I_NOP, 1'b0,   1'b1, 2'd0, I_XOR, 2, 1, 3, 0};
        vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h7F, 32'h33, 2'b01, I_XOR, 1'b0, 1'b1, 2'd0, I_XOR, 3, 1, 0, 0};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b01, I_XOR, 1'b1,   1'b1, 2'd0, I_NOP, 2, 1, 0, 0};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b1,   1'b1, 2'd1, I_XOR, 1, 1, 0, 0};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b1,   1'b0, 2'd0, 32'h0, 0, 1, 0, 0};

        rst = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
        step();
        step();
        check("reset valid", 64'(a_valid), 64'd0);
        check("reset level", 64'(a_level), 64'd0);
        check("reset hit_cnt", a_hit_cnt, 64'd0);
        check("reset drop", 64'(a_drop), 64'd0);
        check("reset evt_ch", 64'(a_ch), 64'd0);
        check("reset evt_insn", 64'(a_insn), 64'd0);
        check("reset evt_snap", a_snap, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].we, vecs[v].idx, vecs[v].en, vecs[v].mask, vecs[v].value,
                  vecs[v].resp, vecs[v].rdata, vecs[v].ready);
            step();
            check($sformatf("v%0d valid", v), 64'(a_valid), 64'(vecs[v].exp_valid));
            check($sformatf("v%0d level", v), 64'(a_level), 64'(vecs[v].exp_level));
            check($sformatf("v%0d cnt0", v), 64'(a_hit_cnt[0 +: CNT_W]), 64'(vecs[v].exp_cnt0));
            check($sformatf("v%0d cnt1", v), 64'(a_hit_cnt[CNT_W +: CNT_W]), 64'(vecs[v].exp_cnt1));
            check($sformatf("v%0d drop", v), 64'(a_drop), 64'(vecs[v].exp_drop));
            if (vecs[v].exp_valid) begin
                check($sformatf("v%0d ch", v), 64'(a_ch), 64'(vecs[v].exp_ch));
                check($sformatf("v%0d insn", v), 64'(a_insn), 64'(vecs[v].exp_insn));
                check($sformatf("v%0d snap", v), a_snap, {vecs[v].exp_insn, ~vecs[v].exp_insn});
            end
        end

        // Fill past DEPTH with the consumer stalled: two records must drop.
        drive(1'b1, 2'd0, 1'b1, XOR_M, XOR_V, 2'b00, 32'h0, 1'b0);
        step();
        check("refill cnt0 cleared", 64'(a_hit_cnt[0 +: CNT_W]), 64'd0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b01, xw(k), 1'b0);
            step();
            check($sformatf("fill%0d level", k), 64'(a_level), 64'((k + 1 > DEPTH) ? DEPTH : k + 1));
            check($sformatf("fill%0d drop", k), 64'(a_drop), 64'((k + 1 > DEPTH) ? k + 1 - DEPTH : 0));
        end
        check("full cnt0", 64'(a_hit_cnt[0 +: CNT_W]), 64'd10);
        check("full head", 64'(a_insn), 64'(xw(0)));

        // Full with push and pop in the same cycle: both happen, no drop.
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b01, xw(10), 1'b1);
        step();
        check("full pushpop level", 64'(a_level), 64'(DEPTH));
        check("full pushpop drop", 64'(a_drop), 64'd2);
        check("full pushpop cnt0", 64'(a_hit_cnt[0 +: CNT_W]), 64'd11);

        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b1);
        for (int j = 0; j < DEPTH; j++) begin
            exp_w = (j < DEPTH - 1) ? xw(j + 1) : xw(10);
            $display("pop %0d: valid=%0d ch=%0d insn=0x%08h snap=0x%016h", j, a_valid, a_ch, a_insn, a_snap);
            check($sformatf("drain%0d valid", j), 64'(a_valid), 64'd1);
            check($sformatf("drain%0d ch", j), 64'(a_ch), 64'd0);
            check($sformatf("drain%0d insn", j), 64'(a_insn), 64'(exp_w));
            check($sformatf("drain%0d snap", j), a_snap, {exp_w, ~exp_w});
            step();
        end
        check("drained valid", 64'(a_valid), 64'd0);
        check("drained level", 64'(a_level), 64'd0);

        // Async reset with records queued, checked before any clock edge.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b01, xw(k), 1'b0);
            step();
        end
        check("prerst level", 64'(a_level), 64'd5);
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async rst valid", 64'(a_valid), 64'd0);
        check("async rst level", 64'(a_level), 64'd0);
        check("async rst hit_cnt", a_hit_cnt, 64'd0);
        check("async rst drop", 64'(a_drop), 64'd0);
        check("async rst oneshot level", 64'(b_level), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // One-shot channel logs only its first hit until rewritten.
        drive(1'b1, 2'd0, 1'b1, XOR_M, XOR_V, 2'b00, 32'h0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b01, xw(k), 1'b0);
            step();
        end
        check("oneshot level", 64'(b_level), 64'd1);
        check("oneshot cnt0", 64'(b_hit_cnt[0 +: CNT_W]), 64'd3);
        check("oneshot head", 64'(b_insn), 64'(xw(0)));
        check("every-hit level", 64'(a_level), 64'd3);
        drive(1'b1, 2'd0, 1'b1, XOR_M, XOR_V, 2'b00, 32'h0, 1'b0);
        step();
        check("oneshot rearm cnt0", 64'(b_hit_cnt[0 +: CNT_W]), 64'd0);
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b01, xw(5), 1'b0);
        step();
        check("oneshot relog level", 64'(b_level), 64'd2);
        check("oneshot relog cnt0", 64'(b_hit_cnt[0 +: CNT_W]), 64'd1);
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b1);
        step();
        check("oneshot second rec", 64'(b_insn), 64'(xw(5)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
